// File: rtl/pwm_mix_out_if.sv
// Interface bundling the voice-mix inputs and the PWM outputs of pwm_mix_out.
// When MIX_PEAK_EN is defined it also carries the peak-hold clear and readback.
interface pwm_mix_out_if #(
    parameter int SAMPLE_W = 7,
    parameter int PWM_W    = 9
);
    logic                ena;
    logic [SAMPLE_W-1:0] sample1;
    logic [SAMPLE_W-1:0] sample2;
    logic [SAMPLE_W-1:0] sample3;
    logic [SAMPLE_W-1:0] sample4;
    logic [3:0]          voice_en;
    logic [7:0]          atten;
    logic                pwm_out;
    logic                frame_strobe;
`ifdef MIX_PEAK_EN
    logic                peak_clr;
    logic [PWM_W-1:0]    peak_level;

    modport master (
        output ena, sample1, sample2, sample3, sample4, voice_en, atten, peak_clr,
        input  pwm_out, frame_strobe, peak_level
    );
    modport slave (
        input  ena, sample1, sample2, sample3, sample4, voice_en, atten, peak_clr,
        output pwm_out, frame_strobe, peak_level
    );
`else
    modport master (
        output ena, sample1, sample2, sample3, sample4, voice_en, atten,
        input  pwm_out, frame_strobe
    );
    modport slave (
        input  ena, sample1, sample2, sample3, sample4, voice_en, atten,
        output pwm_out, frame_strobe
    );
`endif
endinterface

// File: rtl/pwm_mix_out.sv
// pwm_mix_out: sums four attenuated voice samples, one voice per clock at the
// start of each PWM frame, and plays the previous frame's sum as the duty of a
// single-bit PWM output. The duty only changes at frame boundaries.
// Optional feature macro: MIX_PEAK_EN adds a running-maximum peak register of
// the duty with a synchronous clear.
module pwm_mix_out #(
    parameter int SAMPLE_W = 7,
    parameter int PWM_W    = 9
) (
    input  logic          clk,
    input  logic          rst_n,
    pwm_mix_out_if.slave  bus
);

    logic [PWM_W-1:0] r_cnt;
    logic [PWM_W-1:0] r_acc;
    logic [PWM_W-1:0] r_duty;
    logic             r_pwm;
    logic             r_strobe;

    logic [PWM_W-1:0] w_contrib;
    logic [PWM_W-1:0] w_acc_next;
    logic             w_acc_win;
    logic             w_frame_end;

    // Gated, shifted and zero-extended contribution of one voice.
    function automatic logic [PWM_W-1:0] contrib_f(
        input logic                en,
        input logic [SAMPLE_W-1:0] smp,
        input logic [1:0]          sh
    );
        logic [SAMPLE_W-1:0] shifted;
        shifted = smp >> sh;
        return en ? PWM_W'(shifted) : '0;
    endfunction

    assign w_acc_win   = (r_cnt < PWM_W'(4));
    assign w_frame_end = (r_cnt == '1);

    // Pick the voice whose accumulation slot is the current counter value.
    always_comb begin
        w_contrib = '0;
        case (r_cnt[1:0])
            2'd0:    w_contrib = contrib_f(bus.voice_en[0], bus.sample1, bus.atten[1:0]);
            2'd1:    w_contrib = contrib_f(bus.voice_en[1], bus.sample2, bus.atten[3:2]);
            2'd2:    w_contrib = contrib_f(bus.voice_en[2], bus.sample3, bus.atten[5:4]);
            default: w_contrib = contrib_f(bus.voice_en[3], bus.sample4, bus.atten[7:6]);
        endcase
    end

    // Slot 0 restarts the sum; slots 1..3 add onto it.
    assign w_acc_next = (r_cnt == '0) ? w_contrib : (r_acc + w_contrib);

    // Frame counter, sequential mix, duty load and registered PWM compare.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_acc    <= '0;
            r_duty   <= '0;
            r_pwm    <= 1'b0;
            r_strobe <= 1'b0;
        end else begin
            r_strobe <= 1'b0;
            r_pwm    <= 1'b0;
            if (bus.ena) begin
                r_cnt <= r_cnt + PWM_W'(1);
                r_pwm <= (r_cnt < r_duty);
                if (w_acc_win) begin
                    r_acc <= w_acc_next;
                end
                if (w_frame_end) begin
                    r_duty   <= r_acc;
                    r_strobe <= 1'b1;
                end
            end
        end
    end

    assign bus.pwm_out      = r_pwm;
    assign bus.frame_strobe = r_strobe;

`ifdef MIX_PEAK_EN
    logic [PWM_W-1:0] r_peak;

    // Running maximum of every loaded duty; clear wins over a same-cycle load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_peak <= '0;
        end else if (bus.peak_clr) begin
            r_peak <= '0;
        end else if (bus.ena && w_frame_end && (r_acc > r_peak)) begin
            r_peak <= r_acc;
        end
    end

    assign bus.peak_level = r_peak;
`endif

endmodule

// File: tb/tb_pwm_mix_out.sv
// Directed testbench for pwm_mix_out: measures high cycles and length of each
// PWM frame (strobe to strobe) and compares against hand-computed values.
module tb_pwm_mix_out;

    localparam int SAMPLE_W = 7;
    localparam int PWM_W    = 9;

    logic clk;
    logic rst_n;

    pwm_mix_out_if #(.SAMPLE_W(SAMPLE_W), .PWM_W(PWM_W)) bus ();

    pwm_mix_out #(.SAMPLE_W(SAMPLE_W), .PWM_W(PWM_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Frame monitor state (updated on negedge only).
    int frames    = 0;
    int acc_high  = 0;
    int acc_len   = 0;
    int last_high = 0;
    int last_len  = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One window = strobe cycle up to (not including) the next strobe cycle.
    always @(negedge clk) begin
        if (!rst_n) begin
            acc_high = 0;
            acc_len  = 0;
        end else if (bus.frame_strobe) begin
            last_high = acc_high;
            last_len  = acc_len;
            frames++;
            acc_high = int'(bus.pwm_out);
            acc_len  = 1;
        end else begin
            acc_high += int'(bus.pwm_out);
            acc_len++;
        end
    end

    // Wait for n further completed frames, bounded; returns just after a posedge.
    task automatic wait_frames(input int n, input string tag);
        int target;
        target = frames + n;
        for (int i = 0; i < n * 700 + 100; i++) begin
            @(posedge clk);
            if (frames >= target) break;
        end
        chk({tag, "_frame_wait"}, (frames >= target) ? 1 : 0, 1);
    endtask

    task automatic set_samples(input int s1, input int s2, input int s3, input int s4);
        bus.sample1 = SAMPLE_W'(s1);
        bus.sample2 = SAMPLE_W'(s2);
        bus.sample3 = SAMPLE_W'(s3);
        bus.sample4 = SAMPLE_W'(s4);
    endtask

    initial begin
        rst_n        = 1'b0;
        bus.ena      = 1'b1;
        bus.voice_en = 4'hF;
        bus.atten    = 8'h00;
`ifdef MIX_PEAK_EN
        bus.peak_clr = 1'b0;
`endif
        set_samples(0, 0, 0, 0);

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_pwm", int'(bus.pwm_out), 0);
        chk("rst_strobe", int'(bus.frame_strobe), 0);
        rst_n = 1'b1;

        // 1: silent mix, strobe every 512 clocks
        wait_frames(2, "t1");
        chk("t1_high", last_high, 0);
        chk("t1_len", last_len, 512);

        // 2: 100+50+25+10 = 185
        @(negedge clk);
        set_samples(100, 50, 25, 10);
        wait_frames(3, "t2");
        chk("t2_high", last_high, 185);
        chk("t2_len", last_len, 512);

        // Per-voice shifts: 100>>0 + 50>>1 + 25>>2 + 10>>3 = 100+25+6+1
        @(negedge clk);
        bus.atten = {2'd3, 2'd2, 2'd1, 2'd0};
        wait_frames(3, "atten_mix");
        chk("atten_mix_high", last_high, 132);

        // Voice subset: voices 2 and 4 only -> 50+10
        @(negedge clk);
        bus.atten    = 8'h00;
        bus.voice_en = 4'b1010;
        wait_frames(3, "ven_mix");
        chk("ven_mix_high", last_high, 60);

        // 3: single voice 100>>2 = 25, then atten change mid-frame
        @(negedge clk);
        bus.voice_en = 4'b0001;
        bus.atten    = 8'h02;
        wait_frames(3, "t3");
        chk("t3_high", last_high, 25);
        repeat (200) @(negedge clk);
        bus.atten = 8'h00;
        wait_frames(1, "t3_cur");
        chk("t3_cur_high", last_high, 25);
        wait_frames(1, "t3_next");
        chk("t3_next_high", last_high, 25);
        wait_frames(1, "t3_next2");
        chk("t3_next2_high", last_high, 100);

        // 4: full scale 4*127 = 508
        @(negedge clk);
        bus.voice_en = 4'hF;
        set_samples(127, 127, 127, 127);
        wait_frames(3, "t4");
        chk("t4_high", last_high, 508);
        chk("t4_len", last_len, 512);
`ifdef MIX_PEAK_EN
        @(negedge clk);
        chk("t4_peak", int'(bus.peak_level), 508);
        bus.peak_clr = 1'b1;
        @(negedge clk);
        bus.peak_clr = 1'b0;
        chk("t4_peak_clr", int'(bus.peak_level), 0);
`endif

        // 5: stall at cnt=300 for 50 clocks with duty 185
        @(negedge clk);
        set_samples(100, 50, 25, 10);
        wait_frames(3, "t5_pre");
        chk("t5_pre_high", last_high, 185);
        wait_frames(1, "t5_sync");
        @(negedge clk);                  // cnt == 1
        repeat (299) @(negedge clk);     // cnt == 300
        bus.ena = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (i == 0 || i == 49) begin
                chk("t5_stall_pwm", int'(bus.pwm_out), 0);
                chk("t5_stall_strobe", int'(bus.frame_strobe), 0);
            end
        end
        bus.ena = 1'b1;
        wait_frames(1, "t5");
        chk("t5_high", last_high, 185);
        chk("t5_len", last_len, 562);

        // 6: async reset at cnt=100 during the high run
        wait_frames(1, "t6_sync");
        @(negedge clk);                  // cnt == 1
        repeat (99) @(negedge clk);      // cnt == 100
        chk("t6_pre_pwm", int'(bus.pwm_out), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_async_pwm", int'(bus.pwm_out), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        wait_frames(1, "t6_first");
        chk("t6_first_high", last_high, 0);
        wait_frames(1, "t6_second");
        chk("t6_second_high", last_high, 185);
        chk("t6_second_len", last_len, 512);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
